moonbase_sram_arb: RTL and testbench



---
 rtl/moonbase_sram_pkg.sv | 17 +
 rtl/moonbase_arb2.sv | 32 +++
 rtl/moonbase_sram_arb.sv | 128 ++++++++++++
 tb/tb_moonbase_sram_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/moonbase_sram_pkg.sv
// Shared types and constants for the moonbase nibble-SRAM arbiter.
package moonbase_sram_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 4;

    // No address strobe, write-enable and data strobe both deasserted (active-low).
    localparam logic [7:0] BUS_IDLE = 8'h30;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StAck
    } state_e;

endpackage

// File: rtl/moonbase_arb2.sv
// Two-way grant decision. MOONBASE_SRAM_ARB_RR_EN selects round-robin; otherwise port 0 has
// fixed priority and no last-grant pointer is built.
module moonbase_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic gnt1
);

`ifdef MOONBASE_SRAM_ARB_RR_EN
    logic last_q;

    // On contention the port that did not win last time goes first.
    assign gnt1 = req1 && (!req0 || !last_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (grant_en) begin
            last_q <= gnt1;
        end
    end
`else
    logic unused_ok;

    assign gnt1      = req1 && !req0;
    assign unused_ok = ^{clk, rst, grant_en};
`endif

endmodule

// File: rtl/moonbase_sram_arb.sv
// Arbitrates two request ports onto a multiplexed 8-bit nibble-SRAM bus (addr, data, ack).
// Arbitration policy comes from moonbase_arb2 under MOONBASE_SRAM_ARB_RR_EN.
module moonbase_sram_arb
    import moonbase_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] sram_in,
    output logic [7:0]        bus_out
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [7:0]        bus_q, bus_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              win1, grant_en;

    assign grant_en = (state_q == StIdle) && (req0 || req1);

    moonbase_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .grant_en (grant_en),
        .gnt1     (win1)
    );

    // Outputs are computed for the state being entered so they are registered yet on time.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        bus_d    = BUS_IDLE;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StAddr;
                    gnt_d   = win1;
                    we_d    = win1 ? we1 : we0;
                    addr_d  = win1 ? addr1 : addr0;
                    wdata_d = win1 ? wdata1 : wdata0;
                    bus_d   = {1'b1, 7'(addr_d)};
                end
            end
            StAddr: begin
                state_d = StData;
                bus_d   = {2'b00, ~we_q, 1'b0, we_q ? 4'(wdata_q) : 4'h0};
            end
            StData: begin
                state_d = StAck;
                ack0_d  = !gnt_q;
                ack1_d  = gnt_q;
                if (!we_q) begin
                    if (gnt_q) begin
                        rdata1_d = sram_in;
                    end else begin
                        rdata0_d = sram_in;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            bus_q    <= BUS_IDLE;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            bus_q    <= bus_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign bus_out = bus_q;
    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_moonbase_sram_arb.sv
// Directed bench for moonbase_sram_arb with a behavioural SRAM decoding bus_out.
module tb_moonbase_sram_arb;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [6:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [3:0] rdata0, rdata1;
    logic [3:0] sram_in;
    logic [7:0] bus_out;

    int checks   = 0;
    int failures = 0;

`ifdef MOONBASE_SRAM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    moonbase_sram_arb dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack0    (ack0),
        .ack1    (ack1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .sram_in (sram_in),
        .bus_out (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: latch address on strobe, write when data strobe and write-enable are low.
    logic [3:0] mem [128] = '{default: 4'h0};
    logic [6:0] lat_addr  = '0;
    int         wr_cnt    = 0;

    always @(posedge clk) begin
        if (bus_out[7]) begin
            lat_addr <= bus_out[6:0];
        end else if (!bus_out[4] && !bus_out[5]) begin
            mem[lat_addr] <= bus_out[3:0];
            wr_cnt        <= wr_cnt + 1;
        end
    end
    assign sram_in = mem[lat_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontended access on port p; request dropped in the ack cycle.
    task automatic xfer(input int p, input logic w, input logic [6:0] a, input logic [3:0] d,
                        input logic [3:0] exp_rd);
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        tick();
        check("xfer_addr_bus", bus_out, {1'b1, a});
        check("xfer_addr_noack", {ack0, ack1}, 2'b00);
        tick();
        check("xfer_data_bus", bus_out, w ? {4'h0, d} : 8'h20);
        tick();
        check("xfer_ack_bus", bus_out, 8'h30);
        check("xfer_ack0", ack0, p == 0);
        check("xfer_ack1", ack1, p == 1);
        if (!w) check("xfer_rdata", (p == 0) ? rdata0 : rdata1, exp_rd);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("xfer_idle_noack", {ack0, ack1}, 2'b00);
    endtask

    initial begin
        int wr_before;
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        check("rst_bus", bus_out, 8'h30);
        check("rst_acks", {ack0, ack1}, 2'b00);
        check("rst_rdata", {rdata0, rdata1}, 8'h00);
        rst = 1'b1;
        tick();
        check("idle_bus", bus_out, 8'h30);

        // Write 0xA to 0x05 from port 0.
        xfer(0, 1'b1, 7'h05, 4'hA, 4'h0);
        check("mem05_written", mem[5], 4'hA);

        // Read it back on port 1 with no write strobe.
        wr_before = wr_cnt;
        xfer(1, 1'b0, 7'h05, 4'h0, 4'hA);
        check("read_no_strobe", wr_cnt, wr_before);

        xfer(1, 1'b1, 7'h10, 4'h7, 4'h0);
        check("mem10_written", mem[16], 4'h7);

        // Address change during ADDR is ignored.
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h05; wdata0 = 4'h3;
        tick();
        check("chg_addr_bus", bus_out, 8'h85);
        addr0 = 7'h10;
        wdata0 = 4'hF;
        tick();
        check("chg_data_bus", bus_out, 8'h03);
        tick();
        check("chg_ack0", ack0, 1'b1);
        req0 = 1'b0;
        tick();
        check("chg_mem05", mem[5], 4'h3);
        check("chg_mem10", mem[16], 4'h7);

        // Reset during DATA aborts the write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h20; wdata0 = 4'h5;
        tick();
        check("abort_addr_bus", bus_out, 8'hA0);
        tick();
        check("abort_data_bus", bus_out, 8'h05);
        rst = 1'b0;
        tick();
        check("abort_bus", bus_out, 8'h30);
        check("abort_noack", {ack0, ack1}, 2'b00);
        check("abort_rdata1_clr", rdata1, 4'h0);
        req0 = 1'b0;
        tick();
        check("abort_bus_held", bus_out, 8'h30);
        check("abort_noack_held", {ack0, ack1}, 2'b00);
        rst = 1'b1;
        tick();
        check("abort_recover_bus", bus_out, 8'h30);
        check("abort_recover_noack", {ack0, ack1}, 2'b00);

        // Contention: both ports read, held high for four accesses.
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h10;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = RrEn ? i[0] : 1'b0;
            tick();
            check("cont_addr_bus", bus_out, g ? 8'h90 : 8'h85);
            tick();
            check("cont_data_bus", bus_out, 8'h20);
            tick();
            check("cont_ack0", ack0, !g);
            check("cont_ack1", ack1, g);
            check("cont_rdata", g ? rdata1 : rdata0, g ? 4'h7 : 4'h3);
            tick();
            check("cont_idle_noack", {ack0, ack1}, 2'b00);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Back-to-back reads on port 0: ack every fourth cycle.
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'h10;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("b2b_ack0", ack0, (k % 4) == 3);
            check("b2b_ack1", ack1, 1'b0);
            if ((k % 4) == 3) check("b2b_rdata0", rdata0, 4'h7);
        end
        req0 = 1'b0;
        tick();
        check("b2b_end_bus", bus_out, 8'h30);
        check("b2b_end_noack", ack0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
